// File: rtl/serial_adder_arbiter_if.sv
// Requester and serial-adder signal bundle for serial_adder_arbiter.
// slave is the arbiter's view; master drives requests and adder replies.
interface serial_adder_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] req_x;
  logic [4*WIDTH-1:0] req_y;
  logic [3:0]         grant;
  logic [3:0]         ack;
  logic [WIDTH:0]     result;
  logic               timeout_err;
  logic               busy;
  logic               add_start;
  logic [WIDTH-1:0]   add_x;
  logic [WIDTH-1:0]   add_y;
  logic               add_done;
  logic [WIDTH:0]     add_sum;

  modport slave (
    input  req,
    input  req_x,
    input  req_y,
    input  add_done,
    input  add_sum,
    output grant,
    output ack,
    output result,
    output timeout_err,
    output busy,
    output add_start,
    output add_x,
    output add_y
  );

  modport master (
    output req,
    output req_x,
    output req_y,
    output add_done,
    output add_sum,
    input  grant,
    input  ack,
    input  result,
    input  timeout_err,
    input  busy,
    input  add_start,
    input  add_x,
    input  add_y
  );
endinterface

// File: rtl/serial_adder_arbiter.sv
// Round-robin arbiter sharing one serial adder among four requesters.
// Moore FSM IDLE/START/WAIT/RESP with a bounded wait for add_done.
module serial_adder_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 12
) (
  input logic                   clock,
  input logic                   Reset,
  serial_adder_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       win_nxt;
  logic [1:0]       cand;
  logic             found;
  logic [3:0]       grant_q;
  logic [WIDTH:0]   result_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic [CW-1:0]    cnt;
  logic             to_flag;
  logic             done_hit;
  logic             to_hit;

  // search ptr, ptr+1, ... wrapping; first active request wins
  always_comb begin
    found   = 1'b0;
    win_nxt = ptr;
    cand    = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        win_nxt = cand;
      end
    end
  end

  always_comb begin
    sel_x = bus.req_x[0 +: WIDTH];
    sel_y = bus.req_y[0 +: WIDTH];
    unique case (win_nxt)
      2'd1: begin
        sel_x = bus.req_x[WIDTH +: WIDTH];
        sel_y = bus.req_y[WIDTH +: WIDTH];
      end
      2'd2: begin
        sel_x = bus.req_x[2*WIDTH +: WIDTH];
        sel_y = bus.req_y[2*WIDTH +: WIDTH];
      end
      2'd3: begin
        sel_x = bus.req_x[3*WIDTH +: WIDTH];
        sel_y = bus.req_y[3*WIDTH +: WIDTH];
      end
      default: ;
    endcase
  end

  assign done_hit = (state == WAIT) && bus.add_done;
  assign to_hit   = (state == WAIT) && !bus.add_done
                  && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (found) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT:  if (done_hit || to_hit) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!Reset) begin
      ptr      <= '0;
      win      <= '0;
      grant_q  <= '0;
      result_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt      <= '0;
      to_flag  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_q <= 4'b0001 << win_nxt;
            win     <= win_nxt;
            x_q     <= sel_x;
            y_q     <= sel_y;
            to_flag <= 1'b0;
          end
        end
        START: cnt <= '0;
        WAIT: begin
          if (bus.add_done) begin
            result_q <= bus.add_sum;
          end else if (to_hit) begin
            result_q <= '0;
            to_flag  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          ptr     <= win + 2'd1;
          grant_q <= '0;
          to_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.ack         = (state == RESP) ? grant_q : 4'b0000;
  assign bus.result      = result_q;
  assign bus.timeout_err = (state == RESP) && to_flag;
  assign bus.busy        = (state != IDLE);
  assign bus.add_start   = (state == START);
  assign bus.add_x       = x_q;
  assign bus.add_y       = y_q;

endmodule

// File: doc/serial_adder_arbiter.md
SERIAL_ADDER_ARBITER -- requirements
Module: serial_adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, operand width of the shared serial adder.
REQ-002 Parameter TIMEOUT, default 12, maximum WAIT cycles before the arbiter abandons an add.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset: Reset=0 at a rising clock edge resets the block.
REQ-005 req  input  4  level request, one bit per requester 0..3.
REQ-006 req_x  input  4*WIDTH  packed operand x; requester i drives bits [i*WIDTH +: WIDTH].
REQ-007 req_y  input  4*WIDTH  packed operand y; same packing as req_x.
REQ-008 grant  output  4  one-hot; marks the requester currently being served.
REQ-009 ack  output  4  one-hot, one-cycle pulse; marks the requester whose result is on result.
REQ-010 result  output  WIDTH+1  sum returned to the acked requester; valid only while ack is nonzero.
REQ-011 timeout_err  output  1  one-cycle pulse, coincident with ack, when the add timed out.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 add_start  output  1  one-cycle start pulse to the serial adder.
REQ-014 add_x, add_y  output  WIDTH each  operands to the serial adder, registered.
REQ-015 add_done  input  1  adder completion flag.
REQ-016 add_sum  input  WIDTH+1  adder result; sampled only when add_done=1.

Function
REQ-017 FSM states: IDLE, START, WAIT, RESP; all outputs are registered or decoded from state only (Moore).
REQ-018 IDLE: req is sampled only in IDLE; if req!=0, select the winner round-robin, starting at pointer ptr and searching ptr, ptr+1, ... mod 4.
REQ-019 On selection: grant<=onehot(winner); add_x/add_y<=winner's operands; next state START.
REQ-020 Operands are latched at grant; later changes to req_x/req_y are ignored for that transaction.
REQ-021 START: add_start=1 for exactly this one cycle; wait counter cleared; next state WAIT.
REQ-022 WAIT: if add_done=1, result<=add_sum and next state RESP; otherwise increment the counter.
REQ-023 If the counter reaches TIMEOUT without add_done: result<=0, timeout_err flag set, next state RESP.
REQ-024 RESP: ack=grant for one cycle; timeout_err asserted in this cycle only if it was flagged; ptr<=winner+1 mod 4; grant<=0; next state IDLE.
REQ-025 If a granted requester drops req, the transaction still completes and ack still pulses.
REQ-026 add_done is ignored in IDLE, START and RESP.
REQ-027 Latency: req sampled at edge k gives grant at k+1, add_start in cycle k+1, and ack one cycle after add_done is sampled. The minimum transaction is 4 cycles plus adder latency.
REQ-028 A requester holding req continuously is re-served only after every other active requester has been served once.

Reset
REQ-029 Reset=0 at any edge (including mid-transaction) forces: state IDLE; ptr=0; grant=0, ack=0, result=0, timeout_err=0, busy=0, add_start=0, add_x=0, add_y=0; counter=0.
REQ-030 The adder is not aborted by reset; any add_done it returns after reset is ignored per REQ-026.

Verification
REQ-031 Single request: after reset, req=0001, x0=5, y0=9, adder model returns Done 5 cycles after start -> grant=0001, one add_start pulse, ack=0001 with result=14, timeout_err=0.
REQ-032 Full contention: req=1111 held from reset, x_i=i, y_i=15 -> acks in order 0001,0010,0100,1000,0001 with results 15,16,17,18,15.
REQ-033 Overflow: x=15, y=15 -> result=30 (carry in bit WIDTH).
REQ-034 Timeout: adder model never asserts Done -> ack pulses TIMEOUT+1 cycles after add_start with result=0 and timeout_err=1; the next request is served normally.
REQ-035 Reset mid-WAIT: Reset=0 for one edge during WAIT, then a late add_done=1 -> all outputs 0, no ack, and the next request is arbitrated from ptr=0.
REQ-036 Operand change and req drop: after grant, x changes from 3 to 7 and req drops -> result uses x=3, and ack still pulses once.
